// File: rtl/trisc_pkg.sv
// trisc_pkg: opcode and ALU select constants, sequencer state encoding and opcode classification helpers.
package trisc_pkg;
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_INC = 4'h6;
    localparam logic [3:0] OP_CLR = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JPN = 4'h9;
    localparam logic [3:0] OP_JPZ = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_XOR  = 3'd3;
    localparam logic [2:0] ALU_INC  = 3'd4;
    localparam logic [2:0] ALU_CLR  = 3'd5;
    typedef enum logic [2:0] {S_IDLE, S_FETCH1, S_FETCH2, S_DECODE, S_EXEC, S_HALT} state_t;
    function automatic logic is_mem_op(input logic [3:0] op);
        return op inside {OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_XOR};
    endfunction
    function automatic logic is_legal(input logic [3:0] op);
        return is_mem_op(op) || (op inside {OP_INC, OP_CLR, OP_JMP, OP_JPN, OP_JPZ, OP_HLT});
    endfunction
endpackage

// File: rtl/trisc_control_sequencer.sv
// trisc_control_sequencer: fetch/decode/execute FSM driving TRISC datapath strobes plus retired-instruction counter.
// Define ILLEGAL_TRAP_EN to halt on undefined opcodes and expose the sticky illegal_op flag.
module trisc_control_sequencer
    import trisc_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int ALUW = 3,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero_flag,
    input  logic            neg_flag,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            mar_from_pc,
    output logic            mar_from_ir,
    output logic            ir_load,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            acc_load,
    output logic [ALUW-1:0] alu_op,
    output logic            halted,
`ifdef ILLEGAL_TRAP_EN
    output logic            illegal_op,
`endif
    output logic [CNTW-1:0] instr_count
);
    state_t state, nxt;
    logic bad, retire, exec_alu;
`ifdef ILLEGAL_TRAP_EN
    assign bad = !is_legal(opcode);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) illegal_op <= 1'b0;
        else if (state == S_DECODE && bad) illegal_op <= 1'b1;
`else
    assign bad = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = run ? S_FETCH1 : S_IDLE;
            S_FETCH1: nxt = S_FETCH2;
            S_FETCH2: nxt = S_DECODE;
            S_DECODE: nxt = (opcode == OP_HLT || bad) ? S_HALT : is_mem_op(opcode) ? S_EXEC : S_FETCH1;
            S_EXEC:   nxt = S_FETCH1;
            default:  nxt = S_HALT;
        endcase
    end
    // STA is the only memory-operand instruction that writes instead of loading ACC
    assign exec_alu = state == S_EXEC && opcode != OP_STA;
    always_comb begin
        mar_from_pc = state == S_FETCH1;
        ir_load     = state == S_FETCH2;
        pc_inc      = state == S_FETCH2;
        mem_rd      = state == S_FETCH2 || exec_alu;
        mem_wr      = state == S_EXEC && opcode == OP_STA;
        mar_from_ir = state == S_DECODE && is_mem_op(opcode);
        acc_load    = exec_alu || (state == S_DECODE && (opcode == OP_INC || opcode == OP_CLR));
        pc_load     = state == S_DECODE && (opcode == OP_JMP || (opcode == OP_JPZ && zero_flag) ||
                                            (opcode == OP_JPN && neg_flag));
        halted      = state == S_HALT;
        alu_op      = !exec_alu && state != S_DECODE ? ALU_PASS :
                      exec_alu && opcode == OP_ADD ? ALU_ADD :
                      exec_alu && opcode == OP_SUB ? ALU_SUB :
                      exec_alu && opcode == OP_XOR ? ALU_XOR :
                      state == S_DECODE && opcode == OP_INC ? ALU_INC :
                      state == S_DECODE && opcode == OP_CLR ? ALU_CLR : ALU_PASS;
    end
    // HLT retires; a trapped illegal opcode does not
    assign retire = (state == S_DECODE && nxt != S_EXEC && !bad) || state == S_EXEC;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) instr_count <= '0;
        else if (retire) instr_count <= instr_count + 1'b1;
endmodule

// File: tb/tb_trisc_control_sequencer.sv
// tb_trisc_control_sequencer: directed self-checking bench for trisc_control_sequencer.
// Honours ILLEGAL_TRAP_EN to match the DUT build.
module tb_trisc_control_sequencer;
    // sig layout: pc_inc pc_load mar_from_pc mar_from_ir ir_load mem_rd mem_wr acc_load alu_op[2:0] halted
    localparam logic [11:0] S_NONE = 12'h000, S_F1 = 12'h200, S_F2 = 12'h8C0, S_DMEM = 12'h100;
    localparam logic [11:0] S_LDA = 12'h050, S_ADD = 12'h052, S_SUB = 12'h054, S_XOR = 12'h056;
    localparam logic [11:0] S_STA = 12'h020, S_INC = 12'h018, S_CLR = 12'h01A, S_JMP = 12'h400;
    localparam logic [11:0] S_HALT = 12'h001;
    logic clk = 0, rst_n = 0, run = 0, zero_flag = 0, neg_flag = 0, rst_w = 0;
    logic [3:0] opcode = 4'h0;
    logic pc_inc, pc_load, mar_from_pc, mar_from_ir, ir_load, mem_rd, mem_wr, acc_load, halted;
    logic [2:0] alu_op;
    logic [15:0] instr_count;
    logic w_pc_inc, w_pc_load, w_mar_pc, w_mar_ir, w_ir_load, w_mem_rd, w_mem_wr, w_acc_load, w_halted;
    logic [2:0] w_alu_op, w_cnt;
`ifdef ILLEGAL_TRAP_EN
    logic illegal_op, w_illegal;
`endif
    int checks = 0, failures = 0;
    logic [15:0] exp_cnt = 0;
    logic [11:0] sig;
    assign sig = {pc_inc, pc_load, mar_from_pc, mar_from_ir, ir_load, mem_rd, mem_wr, acc_load, alu_op, halted};
    always #5 clk = ~clk;

    trisc_control_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero_flag(zero_flag), .neg_flag(neg_flag),
        .pc_inc(pc_inc), .pc_load(pc_load), .mar_from_pc(mar_from_pc), .mar_from_ir(mar_from_ir),
        .ir_load(ir_load), .mem_rd(mem_rd), .mem_wr(mem_wr), .acc_load(acc_load), .alu_op(alu_op),
        .halted(halted),
`ifdef ILLEGAL_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .instr_count(instr_count)
    );

    // narrow-counter instance running INC forever to reach the wrap point quickly
    trisc_control_sequencer #(.CNTW(3)) dut_w (
        .clk(clk), .rst_n(rst_w), .run(1'b1), .opcode(4'h6), .zero_flag(1'b0), .neg_flag(1'b0),
        .pc_inc(w_pc_inc), .pc_load(w_pc_load), .mar_from_pc(w_mar_pc), .mar_from_ir(w_mar_ir),
        .ir_load(w_ir_load), .mem_rd(w_mem_rd), .mem_wr(w_mem_wr), .acc_load(w_acc_load), .alu_op(w_alu_op),
        .halted(w_halted),
`ifdef ILLEGAL_TRAP_EN
        .illegal_op(w_illegal),
`endif
        .instr_count(w_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // runs one instruction starting and ending in FETCH1
    task automatic do_instr(input string nm, input logic [3:0] op, input logic z, input logic n,
                            input logic [11:0] edec, input logic mem, input logic [11:0] eexe);
        checks++;
        if (sig !== S_F1) begin failures++; $display("FAIL %s fetch1: sig=%h expected %h", nm, sig, S_F1); end
        opcode = op; zero_flag = z; neg_flag = n;
        step();
        checks++;
        if (sig !== S_F2) begin failures++; $display("FAIL %s fetch2: sig=%h expected %h", nm, sig, S_F2); end
        step();
        checks++;
        if (sig !== edec) begin failures++; $display("FAIL %s decode: sig=%h expected %h", nm, sig, edec); end
        if (mem) begin
            step();
            checks++;
            if (sig !== eexe) begin failures++; $display("FAIL %s exec: sig=%h expected %h", nm, sig, eexe); end
        end
        step();
        exp_cnt++;
        checks++;
        if (instr_count !== exp_cnt || sig !== S_F1) begin
            failures++;
            $display("FAIL %s retire: count=%0d sig=%h expected count=%0d sig=%h", nm, instr_count, sig, exp_cnt, S_F1);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; run = 1; opcode = 4'h2;
        repeat (3) step();
        checks++;
        if (sig !== S_NONE || instr_count !== 16'd0) begin
            failures++; $display("FAIL reset: sig=%h count=%0d expected %h 0", sig, instr_count, S_NONE);
        end
        rst_n = 1;
        step();
        checks++;
        if (sig !== S_F1) begin failures++; $display("FAIL start: sig=%h expected %h", sig, S_F1); end
    endtask

    task automatic test_add();
        do_instr("add", 4'h2, 0, 0, S_DMEM, 1, S_ADD);
    endtask

    task automatic test_alu();
        run = 0;
        do_instr("lda", 4'h0, 0, 0, S_DMEM, 1, S_LDA);
        do_instr("sub", 4'h3, 0, 0, S_DMEM, 1, S_SUB);
        do_instr("xor", 4'h4, 1, 1, S_DMEM, 1, S_XOR);
        do_instr("inc", 4'h6, 0, 0, S_INC, 0, S_NONE);
        do_instr("clr", 4'h7, 0, 0, S_CLR, 0, S_NONE);
        do_instr("jmp", 4'h8, 0, 0, S_JMP, 0, S_NONE);
    endtask

    task automatic test_branch();
        do_instr("jpz_taken", 4'hC, 1, 0, S_JMP, 0, S_NONE);
        do_instr("jpz_not", 4'hC, 0, 1, S_NONE, 0, S_NONE);
        do_instr("jpn_taken", 4'h9, 0, 1, S_JMP, 0, S_NONE);
        do_instr("jpn_not", 4'h9, 1, 0, S_NONE, 0, S_NONE);
    endtask

    task automatic test_sta();
        do_instr("sta", 4'h1, 0, 0, S_DMEM, 1, S_STA);
    endtask

    task automatic test_nop();
`ifdef ILLEGAL_TRAP_EN
        opcode = 4'hA;
        step();
        step();
        checks++;
        if (sig !== S_NONE) begin failures++; $display("FAIL trap decode: sig=%h expected %h", sig, S_NONE); end
        step();
        checks++;
        if (sig !== S_HALT || illegal_op !== 1'b1 || instr_count !== exp_cnt) begin
            failures++;
            $display("FAIL trap: sig=%h ill=%b count=%0d expected %h 1 %0d", sig, illegal_op, instr_count, S_HALT, exp_cnt);
        end
        rst_n = 0; run = 1;
        #1;
        checks++;
        if (illegal_op !== 1'b0 || sig !== S_NONE) begin
            failures++; $display("FAIL trap reset: ill=%b sig=%h expected 0 %h", illegal_op, sig, S_NONE);
        end
        exp_cnt = 0;
        step();
        rst_n = 1;
        step();
`else
        do_instr("nop_a", 4'hA, 1, 1, S_NONE, 0, S_NONE);
        do_instr("nop_5", 4'h5, 0, 0, S_NONE, 0, S_NONE);
`endif
    endtask

    task automatic test_halt();
        checks++;
        if (sig !== S_F1) begin failures++; $display("FAIL hlt fetch1: sig=%h expected %h", sig, S_F1); end
        opcode = 4'hF;
        step();
        step();
        checks++;
        if (sig !== S_NONE) begin failures++; $display("FAIL hlt decode: sig=%h expected %h", sig, S_NONE); end
        exp_cnt++;
        for (int i = 0; i < 20; i++) begin
            step();
            run = ~run;
            checks++;
            if (sig !== S_HALT || instr_count !== exp_cnt) begin
                failures++;
                $display("FAIL hlt hold %0d: sig=%h count=%0d expected %h %0d", i, sig, instr_count, S_HALT, exp_cnt);
            end
        end
        rst_n = 0;
        #1;
        checks++;
        if (sig !== S_NONE || instr_count !== 16'd0) begin
            failures++; $display("FAIL hlt reset: sig=%h count=%0d expected %h 0", sig, instr_count, S_NONE);
        end
    endtask

    task automatic test_wrap();
        rst_w = 1;
        step();
        for (int i = 1; i <= 8; i++) begin
            repeat (3) step();
            if (i == 7) begin
                checks++;
                if (w_cnt !== 3'd7) begin failures++; $display("FAIL wrap pre: count=%0d expected 7", w_cnt); end
            end
        end
        checks++;
        if (w_cnt !== 3'd0 || w_acc_load !== 1'b0 || w_mar_pc !== 1'b1) begin
            failures++; $display("FAIL wrap: count=%0d acc=%b mar=%b expected 0 0 1", w_cnt, w_acc_load, w_mar_pc);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu();
        test_branch();
        test_sta();
        test_nop();
        test_halt();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
